jtvigil_romslot: RTL and testbench
==================================

// Module: jtvigil_romslot
// PURPOSE
// - One ROM read slot between a game-side requester and one SDRAM bank port.
// - Converts cs/addr requests into bank requests (addr/req, ack, dst, rdy).
// - Assembles 16-bit SDRAM beats into 8/16/32-bit data.
// - Holds a 2-entry cache so repeated fetches from tile, obj and CPU fetchers
//   do not hit the SDRAM.
// - Instantiated once per slot; the bank mux arbitrates between slot outputs.
// PARAMETERS
// - DW      32  slot data width: 8, 16 or 32. Any other value is a $error at elaboration.
// - AW      18  slot address width, in units of DW.
// - OFFSET  0   22-bit word offset added to every SDRAM address (region start in the bank).
// PORTS
// - clk          in   1   system clock; all logic on rising edge
// - rst_n        in   1   asynchronous active-low reset
// - clr          in   1   sync cache flush (held high during download)
// - slot_cs      in   1   request strobe; level, held until slot_ok
// - slot_addr    in   AW  requested address
// - slot_dout    out  DW  data for slot_addr, valid when slot_ok=1
// - slot_ok      out  1   data valid for the current slot_addr
// - sdram_addr   out  22  16-bit word address sent to the bank
// - sdram_req    out  1   bank request; held until sdram_ack
// - sdram_ack    in   1   bank accepted the request (1 cycle)
// - data_dst     in   1   data_read holds a beat for this bank
// - data_rdy     in   1   last beat of this transfer
// - data_read    in   16  SDRAM read data
// BEHAVIOUR
// - Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0.
// - Reset clears both cache valids and sets state to IDLE.
// - Word address:
//   - DW=8:  wa = slot_addr>>1 + OFFSET; byte lane = addr[0] (0 -> [7:0], 1 -> [15:8]).
//   - DW=16: wa = slot_addr + OFFSET.
//   - DW=32: wa = {slot_addr,1'b0} + OFFSET.
//   - All sums are 22-bit and wrap modulo 2^22.
// - Cache entry: {valid, tag[21:0]=wa, data[31:0]}. DW=32: beat0 -> [15:0], beat1 -> [31:16].
// - Hit: cs=1 and tag==wa on a valid entry.
//   - slot_dout and slot_ok are registered: slot_ok rises 1 cycle after cs and addr are stable.
//   - If both entries match (after a refill race), entry 0 wins.
// - slot_ok = ok_r & slot_cs & (slot_addr == addr_q).
//   - It falls in the same cycle that cs drops or addr changes. No stale data is ever flagged ok.
// - FSM states: IDLE, REQ, WAIT, FILL.
//   - IDLE: on cs & miss, latch wa and go to REQ (sdram_req=1 next cycle).
//   - REQ: hold req and addr stable until sdram_ack; then req=0 and go to WAIT.
//     Do not drop the request if cs falls.
//   - WAIT: on each data_dst, store the beat into the 32-bit staging register at the beat counter.
//     Go to FILL on data_rdy. The counter resets at REQ.
//   - FILL: write the staging register into the victim entry, set valid, toggle the
//     victim pointer, then return to IDLE. The IDLE hit check delivers ok.
// - Miss latency: cs to req is 1 cycle; rdy to slot_ok is 2 cycles.
// - Hit latency: 1 cycle.
// - cs dropped or addr changed mid-fetch: the fetch still completes and fills the cache.
//   A new miss is serviced only after FILL.
// - data_dst without a pending fetch (IDLE, REQ) is ignored.
// - data_rdy in the same cycle as data_dst: that beat is stored, then go to FILL.
// - clr:
//   - Clears valids and ok_r the same cycle.
//   - In REQ or WAIT the transfer finishes, but the FILL write leaves the entry invalid.
// - Replacement: 1-bit round-robin victim pointer; reset value 0.
// - Async reset mid-transfer: sdram_req drops immediately.
//   Late data_dst/rdy are ignored because state is IDLE.
// STRUCTURE
// - Shared package jtvigil_pkg:
//   - state enum {IDLE,REQ,WAIT,FILL}
//   - BANK_AW=22
//   - function beats(DW) returning 1 or 2
// - One sub-module, jtvigil_romslot_cache: 2-entry tag/data store with the hit
//   compare, fill port, victim pointer and clr.
// - Address and width logic and the FSM stay in the top module.
// TESTING
// - DW=32, OFFSET=0x100, cs with addr=0x10:
//   -> sdram_addr=0x120 and req stays high until ack.
//   -> beats 0x1111, 0x2222 -> dout=0x22221111 and ok 2 cycles after rdy.
// - Same addr again after cs low for 3 cycles:
//   -> no sdram_req; ok 1 cycle after cs.
// - DW=8, addr=0x21 then 0x20:
//   -> one fetch of wa=0x10, beat 0xABCD -> dout=0xAB; then 0xCD from cache with no req.
// - Three distinct misses A, B, C, then A:
//   -> C evicts A (round-robin) and A refetches; B still hits.
// - cs drop during WAIT, and clr during WAIT:
//   -> ok stays 0 and the transfer completes.
//   -> with clr, the re-request for the same addr issues a new req.
// - rst_n low during REQ:
//   -> req=0 asynchronously.
//   -> a late data_rdy after release causes no fill and no ok.

Source files
------------

// File: rtl/jtvigil_pkg.sv
// Shared types and helpers for the jtvigil ROM slot: FSM states, bank address
// width and the number of 16-bit SDRAM beats per slot word.
package jtvigil_pkg;

    localparam int BANK_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    function automatic int beats(input int dw);
        if (dw == 32) begin
            return 2;
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/jtvigil_romslot_cache.sv
// Two-entry tag/data store for one ROM slot: parallel hit compare with entry 0
// priority, a single fill port, round-robin victim pointer and a flush input.
module jtvigil_romslot_cache
    import jtvigil_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic [BANK_AW-1:0] i_wa,
    output logic               o_hit,
    output logic [31:0]        o_data,
    input  logic               i_fill_we,
    input  logic               i_fill_valid,
    input  logic [BANK_AW-1:0] i_fill_tag,
    input  logic [31:0]        i_fill_data
);

    logic [1:0]         r_valid;
    logic [BANK_AW-1:0] r_tag  [2];
    logic [31:0]        r_data [2];
    logic               r_victim;
    logic [1:0]         w_match;

    // Hit compare; entry 0 wins if both entries hold the same tag
    always_comb begin
        w_match[0] = r_valid[0] & (r_tag[0] == i_wa);
        w_match[1] = r_valid[1] & (r_tag[1] == i_wa);
        o_hit      = |w_match;
        if (w_match[0]) begin
            o_data = r_data[0];
        end else if (w_match[1]) begin
            o_data = r_data[1];
        end else begin
            o_data = 32'd0;
        end
    end

    // Entry storage; a flush overrides the valid bit written by a same-cycle fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 2'b00;
            r_victim <= 1'b0;
            r_tag[0] <= {BANK_AW{1'b0}};
            r_tag[1] <= {BANK_AW{1'b0}};
            r_data[0] <= 32'd0;
            r_data[1] <= 32'd0;
        end else begin
            if (i_clr) begin
                r_valid <= 2'b00;
            end else if (i_fill_we) begin
                r_valid[r_victim] <= i_fill_valid;
            end
            if (i_fill_we) begin
                r_tag[r_victim]  <= i_fill_tag;
                r_data[r_victim] <= i_fill_data;
                r_victim         <= ~r_victim;
            end
        end
    end

endmodule

// File: rtl/jtvigil_romslot.sv
// One ROM read slot: maps slot addresses onto SDRAM word addresses, fetches
// misses through a single bank port and serves repeats from a 2-entry cache.
module jtvigil_romslot
    import jtvigil_pkg::*;
#(
    parameter int          DW     = 32,
    parameter int          AW     = 18,
    parameter logic [21:0] OFFSET = 22'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               slot_cs,
    input  logic [AW-1:0]      slot_addr,
    output logic [DW-1:0]      slot_dout,
    output logic               slot_ok,
    output logic [BANK_AW-1:0] sdram_addr,
    output logic               sdram_req,
    input  logic               sdram_ack,
    input  logic               data_dst,
    input  logic               data_rdy,
    input  logic [15:0]        data_read
);

    localparam int NBEATS = beats(DW);

    state_t             r_state;
    state_t             w_state_nx;
    logic [BANK_AW-1:0] w_base;
    logic [BANK_AW-1:0] w_wa;
    logic               w_hit;
    logic               w_hit_eff;
    logic               w_miss;
    logic [31:0]        w_hit_data;
    logic [DW-1:0]      w_dout_sel;
    logic               w_fill_we;
    logic               w_fill_valid;

    logic [BANK_AW-1:0] r_sdram_addr;
    logic               r_sdram_req;
    logic               r_beat;
    logic [31:0]        r_stage;
    logic               r_clr_seen;
    logic               r_ok;
    logic [AW-1:0]      r_addr_q;
    logic [DW-1:0]      r_dout;

    if (DW != 8 && DW != 16 && DW != 32) begin : g_bad_dw
        $error("jtvigil_romslot: DW must be 8, 16 or 32");
    end

    if (DW == 8) begin : g_dw8
        assign w_base     = BANK_AW'(slot_addr >> 1);
        assign w_dout_sel = slot_addr[0] ? w_hit_data[15:8] : w_hit_data[7:0];
    end else if (DW == 16) begin : g_dw16
        assign w_base     = BANK_AW'(slot_addr);
        assign w_dout_sel = w_hit_data[15:0];
    end else begin : g_dw32
        assign w_base     = BANK_AW'({slot_addr, 1'b0});
        assign w_dout_sel = w_hit_data;
    end

    assign w_wa = w_base + OFFSET;

    jtvigil_romslot_cache u_cache (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (clr),
        .i_wa         (w_wa),
        .o_hit        (w_hit),
        .o_data       (w_hit_data),
        .i_fill_we    (w_fill_we),
        .i_fill_valid (w_fill_valid),
        .i_fill_tag   (r_sdram_addr),
        .i_fill_data  (r_stage)
    );

    // A flush seen at any point of the transfer keeps the refilled entry invalid
    always_comb begin
        w_hit_eff    = w_hit & ~clr;
        w_miss       = slot_cs & ~w_hit_eff;
        w_fill_we    = (r_state == ST_FILL);
        w_fill_valid = ~(r_clr_seen | clr);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_nx = ST_REQ;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    w_state_nx = ST_WAIT;
                end else begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_rdy) begin
                    w_state_nx = ST_FILL;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_FILL: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Bank request, beat staging and registered hit delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= {BANK_AW{1'b0}};
            r_beat       <= 1'b0;
            r_stage      <= 32'd0;
            r_clr_seen   <= 1'b0;
            r_ok         <= 1'b0;
            r_addr_q     <= {AW{1'b0}};
            r_dout       <= {DW{1'b0}};
        end else begin
            if (r_state == ST_IDLE && slot_cs && w_hit_eff) begin
                r_ok     <= 1'b1;
                r_addr_q <= slot_addr;
                r_dout   <= w_dout_sel;
            end else begin
                r_ok <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_sdram_req  <= 1'b1;
                        r_sdram_addr <= w_wa;
                        r_beat       <= 1'b0;
                        r_stage      <= 32'd0;
                        r_clr_seen   <= clr;
                    end
                end
                ST_REQ: begin
                    if (clr) begin
                        r_clr_seen <= 1'b1;
                    end
                    if (sdram_ack) begin
                        r_sdram_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (clr) begin
                        r_clr_seen <= 1'b1;
                    end
                    if (data_dst) begin
                        if (NBEATS == 1 || r_beat == 1'b0) begin
                            r_stage[15:0] <= data_read;
                        end else begin
                            r_stage[31:16] <= data_read;
                        end
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_FILL: begin
                    r_beat <= 1'b0;
                end
                default: begin
                    r_beat <= 1'b0;
                end
            endcase
        end
    end

    assign sdram_req  = r_sdram_req;
    assign sdram_addr = r_sdram_addr;
    assign slot_dout  = r_dout;
    assign slot_ok    = r_ok & slot_cs & (slot_addr == r_addr_q);

endmodule

// File: tb/tb_jtvigil_romslot.sv
// Self-checking bench for jtvigil_romslot: a DW=32/OFFSET=0x100 slot and a DW=8
// slot, checked against a behavioural 2-entry round-robin cache and SDRAM model.
module tb_jtvigil_romslot;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr32 = 1'b0, cs32 = 1'b0, ack32 = 1'b0, dst32 = 1'b0, rdy32 = 1'b0;
    logic [17:0] addr32 = 18'd0;
    logic [15:0] rd32 = 16'd0;
    logic [31:0] dout32;
    logic        ok32, req32;
    logic [21:0] sa32;

    logic        clr8 = 1'b0, cs8 = 1'b0, ack8 = 1'b0, dst8 = 1'b0, rdy8 = 1'b0;
    logic [17:0] addr8 = 18'd0;
    logic [15:0] rd8 = 16'd0;
    logic [7:0]  dout8;
    logic        ok8, req8;
    logic [21:0] sa8;

    int n_vec = 0;
    int n_err = 0;

    logic [21:0] m_tag  [2];
    logic [31:0] m_data [2];
    bit          m_val  [2];
    bit          m_vic;

    jtvigil_romslot #(.DW(32), .AW(18), .OFFSET(22'h100)) u32 (
        .clk(clk), .rst_n(rst_n), .clr(clr32), .slot_cs(cs32), .slot_addr(addr32),
        .slot_dout(dout32), .slot_ok(ok32), .sdram_addr(sa32), .sdram_req(req32),
        .sdram_ack(ack32), .data_dst(dst32), .data_rdy(rdy32), .data_read(rd32)
    );

    jtvigil_romslot #(.DW(8), .AW(18), .OFFSET(22'h0)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr8), .slot_cs(cs8), .slot_addr(addr8),
        .slot_dout(dout8), .slot_ok(ok8), .sdram_addr(sa8), .sdram_req(req8),
        .sdram_ack(ack8), .data_dst(dst8), .data_rdy(rdy8), .data_read(rd8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mem_word(input logic [21:0] wa);
        return wa[15:0] ^ 16'hC35A ^ {wa[21:16], 10'd0};
    endfunction

    function automatic logic [21:0] wa32(input logic [17:0] a);
        return 22'({a, 1'b0}) + 22'h100;
    endfunction

    task automatic m_reset();
        m_val[0] = 1'b0; m_val[1] = 1'b0; m_vic = 1'b0;
    endtask

    task automatic m_fill(input logic [21:0] w, input logic [31:0] d, input bit v);
        m_tag[m_vic] = w; m_data[m_vic] = d; m_val[m_vic] = v; m_vic = ~m_vic;
    endtask

    // Model lookup; a miss refills the victim with the SDRAM contents
    task automatic predict32(input logic [17:0] a, output bit hit, output logic [31:0] d);
        logic [21:0] w;
        w = wa32(a);
        hit = 1'b0;
        if (m_val[0] && m_tag[0] == w) begin
            hit = 1'b1; d = m_data[0];
        end else if (m_val[1] && m_tag[1] == w) begin
            hit = 1'b1; d = m_data[1];
        end else begin
            d = {mem_word(w + 22'd1), mem_word(w)};
            m_fill(w, d, 1'b1);
        end
    endtask

    // One slot read on the 32-bit slot, acting as the bank with random delays
    task automatic access32(input logic [17:0] a, output bit saw_req, output logic [21:0] req_addr,
                            output int lat, output logic [31:0] dout, output bit ok_seen);
        int n;
        saw_req = 1'b0; req_addr = 22'd0; lat = 0;
        cs32 = 1'b1; addr32 = a;
        n = 0;
        while (!ok32 && !req32 && n < 20) begin tick(); n++; end
        if (req32) begin
            saw_req = 1'b1; req_addr = sa32;
            repeat ($urandom_range(0, 3)) tick();
            ack32 = 1'b1; tick(); ack32 = 1'b0;
            for (int b = 0; b < 2; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                dst32 = 1'b1; rd32 = mem_word(req_addr + 22'(b)); rdy32 = (b == 1);
                tick();
                dst32 = 1'b0; rdy32 = 1'b0;
            end
            n = 0;
            while (!ok32 && n < 20) begin tick(); n++; end
        end
        lat = n; ok_seen = ok32; dout = dout32;
        cs32 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_vec++; if (req32 !== 1'b0) begin n_err++; $display("FAIL rst_req32 got %b want 0", req32); end
        n_vec++; if (sa32 !== 22'd0) begin n_err++; $display("FAIL rst_addr32 got %h want 0", sa32); end
        n_vec++; if (dout32 !== 32'd0) begin n_err++; $display("FAIL rst_dout32 got %h want 0", dout32); end
        n_vec++; if (ok32 !== 1'b0) begin n_err++; $display("FAIL rst_ok32 got %b want 0", ok32); end
        n_vec++; if (req8 !== 1'b0 || dout8 !== 8'd0) begin n_err++; $display("FAIL rst_8 got req=%b dout=%h want 0/00", req8, dout8); end
    endtask

    task automatic test_miss();
        cs32 = 1'b1; addr32 = 18'h10;
        tick();
        n_vec++; if (req32 !== 1'b1) begin n_err++; $display("FAIL miss_req got %b want 1", req32); end
        n_vec++; if (sa32 !== 22'h120) begin n_err++; $display("FAIL miss_addr got %h want 120", sa32); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (req32 !== 1'b1 || sa32 !== 22'h120) begin n_err++; $display("FAIL miss_hold got req=%b addr=%h want 1/120", req32, sa32); end
        end
        ack32 = 1'b1; tick(); ack32 = 1'b0;
        n_vec++; if (req32 !== 1'b0) begin n_err++; $display("FAIL miss_ackdrop got %b want 0", req32); end
        dst32 = 1'b1; rd32 = 16'h1111; tick();
        rd32 = 16'h2222; rdy32 = 1'b1; tick();
        dst32 = 1'b0; rdy32 = 1'b0;
        tick();
        n_vec++; if (ok32 !== 1'b0) begin n_err++; $display("FAIL miss_ok_early got %b want 0", ok32); end
        tick();
        n_vec++; if (ok32 !== 1'b1) begin n_err++; $display("FAIL miss_ok_2cyc got %b want 1", ok32); end
        n_vec++; if (dout32 !== 32'h22221111) begin n_err++; $display("FAIL miss_dout got %h want 22221111", dout32); end
        m_fill(22'h120, 32'h22221111, 1'b1);
        cs32 = 1'b0; tick();
    endtask

    task automatic test_hit();
        bit s, okx, eh; logic [21:0] ra; int lat; logic [31:0] d, ed;
        tick(); tick();
        predict32(18'h10, eh, ed);
        access32(18'h10, s, ra, lat, d, okx);
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL hit_noreq got %b want 0", s); end
        n_vec++; if (lat != 1 || okx !== 1'b1) begin n_err++; $display("FAIL hit_lat got %0d ok=%b want 1/1", lat, okx); end
        n_vec++; if (d !== ed) begin n_err++; $display("FAIL hit_dout got %h want %h", d, ed); end
    endtask

    task automatic test_dw8();
        int n;
        cs8 = 1'b1; addr8 = 18'h21;
        tick();
        n_vec++; if (req8 !== 1'b1 || sa8 !== 22'h10) begin n_err++; $display("FAIL dw8_req got req=%b addr=%h want 1/010", req8, sa8); end
        ack8 = 1'b1; tick(); ack8 = 1'b0;
        dst8 = 1'b1; rdy8 = 1'b1; rd8 = 16'hABCD; tick();
        dst8 = 1'b0; rdy8 = 1'b0;
        n = 0;
        while (!ok8 && n < 20) begin tick(); n++; end
        n_vec++; if (n != 2) begin n_err++; $display("FAIL dw8_lat got %0d want 2", n); end
        n_vec++; if (dout8 !== 8'hAB) begin n_err++; $display("FAIL dw8_hi got %h want ab", dout8); end
        cs8 = 1'b0; tick();
        cs8 = 1'b1; addr8 = 18'h20; tick();
        n_vec++; if (req8 !== 1'b0 || ok8 !== 1'b1) begin n_err++; $display("FAIL dw8_hit got req=%b ok=%b want 0/1", req8, ok8); end
        n_vec++; if (dout8 !== 8'hCD) begin n_err++; $display("FAIL dw8_lo got %h want cd", dout8); end
        cs8 = 1'b0; tick();
    endtask

    task automatic test_round_robin();
        logic [17:0] seq [5] = '{18'h40, 18'h50, 18'h60, 18'h50, 18'h40};
        bit          exp_req [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bit s, okx, eh; logic [21:0] ra; int lat; logic [31:0] d, ed;
        for (int i = 0; i < 5; i++) begin
            predict32(seq[i], eh, ed);
            access32(seq[i], s, ra, lat, d, okx);
            n_vec++; if (s !== exp_req[i]) begin n_err++; $display("FAIL rr_req[%0d] got %b want %b", i, s, exp_req[i]); end
            n_vec++; if (d !== {mem_word(wa32(seq[i]) + 22'd1), mem_word(wa32(seq[i]))}) begin
                n_err++; $display("FAIL rr_dout[%0d] got %h want %h", i, d, {mem_word(wa32(seq[i]) + 22'd1), mem_word(wa32(seq[i]))});
            end
        end
    endtask

    task automatic test_cs_drop();
        bit s, okx, eh; logic [21:0] ra, w; int lat; logic [31:0] d, ed;
        w = wa32(18'h70);
        predict32(18'h70, eh, ed);
        cs32 = 1'b1; addr32 = 18'h70; tick();
        n_vec++; if (req32 !== 1'b1) begin n_err++; $display("FAIL csdrop_req got %b want 1", req32); end
        ack32 = 1'b1; tick(); ack32 = 1'b0;
        cs32 = 1'b0;
        dst32 = 1'b1; rd32 = mem_word(w); tick();
        rd32 = mem_word(w + 22'd1); rdy32 = 1'b1; tick();
        dst32 = 1'b0; rdy32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (ok32 !== 1'b0 || req32 !== 1'b0) begin n_err++; $display("FAIL csdrop_idle got ok=%b req=%b want 0/0", ok32, req32); end
        end
        predict32(18'h70, eh, ed);
        access32(18'h70, s, ra, lat, d, okx);
        n_vec++; if (s !== 1'b0 || d !== ed) begin n_err++; $display("FAIL csdrop_filled got req=%b dout=%h want 0/%h", s, d, ed); end
    endtask

    task automatic test_clr_wait();
        bit s, okx, eh; logic [21:0] ra, w; int lat; logic [31:0] d, ed;
        w = wa32(18'h80);
        cs32 = 1'b1; addr32 = 18'h80; tick();
        ack32 = 1'b1; tick(); ack32 = 1'b0;
        clr32 = 1'b1; dst32 = 1'b1; rd32 = mem_word(w); tick();
        clr32 = 1'b0; rd32 = mem_word(w + 22'd1); rdy32 = 1'b1; tick();
        dst32 = 1'b0; rdy32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (ok32 !== 1'b0) begin n_err++; $display("FAIL clr_ok got %b want 0", ok32); end
        end
        n_vec++; if (req32 !== 1'b1 || sa32 !== w) begin n_err++; $display("FAIL clr_rereq got req=%b addr=%h want 1/%h", req32, sa32, w); end
        m_val[0] = 1'b0; m_val[1] = 1'b0;
        m_fill(w, 32'd0, 1'b0);
        predict32(18'h80, eh, ed);
        access32(18'h80, s, ra, lat, d, okx);
        n_vec++; if (s !== 1'b1 || ra !== w) begin n_err++; $display("FAIL clr_fetch got req=%b addr=%h want 1/%h", s, ra, w); end
        n_vec++; if (d !== ed || okx !== 1'b1) begin n_err++; $display("FAIL clr_dout got %h ok=%b want %h/1", d, okx, ed); end
    endtask

    task automatic test_reset_mid();
        bit s, okx, eh; logic [21:0] ra; int lat; logic [31:0] d, ed;
        cs32 = 1'b1; addr32 = 18'h90; tick();
        n_vec++; if (req32 !== 1'b1) begin n_err++; $display("FAIL rstmid_req got %b want 1", req32); end
        cs32 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (req32 !== 1'b0 || sa32 !== 22'd0) begin n_err++; $display("FAIL rstmid_async got req=%b addr=%h want 0/0", req32, sa32); end
        @(negedge clk); rst_n = 1'b1;
        m_reset();
        tick();
        dst32 = 1'b1; rdy32 = 1'b1; rd32 = 16'hDEAD; tick();
        dst32 = 1'b0; rdy32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (req32 !== 1'b0 || ok32 !== 1'b0) begin n_err++; $display("FAIL rstmid_late got req=%b ok=%b want 0/0", req32, ok32); end
        end
        predict32(18'h90, eh, ed);
        access32(18'h90, s, ra, lat, d, okx);
        n_vec++; if (s !== 1'b1 || d !== ed) begin n_err++; $display("FAIL rstmid_nofill got req=%b dout=%h want 1/%h", s, d, ed); end
    endtask

    task automatic test_random();
        logic [17:0] pool [6] = '{18'h10, 18'h40, 18'h50, 18'h3FFFF, 18'h12345, 18'h0};
        bit s, okx, eh; logic [21:0] ra; int lat; logic [31:0] d, ed;
        logic [17:0] a;
        for (int i = 0; i < 40; i++) begin
            a = pool[$urandom_range(0, 5)];
            predict32(a, eh, ed);
            access32(a, s, ra, lat, d, okx);
            n_vec++; if (s !== !eh) begin n_err++; $display("FAIL rnd_req[%0d] a=%h got %b want %b", i, a, s, !eh); end
            n_vec++; if (lat != (eh ? 1 : 2) || okx !== 1'b1) begin n_err++; $display("FAIL rnd_lat[%0d] got %0d ok=%b want %0d/1", i, lat, okx, eh ? 1 : 2); end
            n_vec++; if (d !== ed) begin n_err++; $display("FAIL rnd_dout[%0d] got %h want %h", i, d, ed); end
            if (!eh) begin
                n_vec++; if (ra !== wa32(a)) begin n_err++; $display("FAIL rnd_addr[%0d] got %h want %h", i, ra, wa32(a)); end
            end
        end
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        tick();
        test_reset();
        test_miss();
        test_hit();
        test_dw8();
        test_round_robin();
        test_cs_drop();
        test_clr_wait();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
